decode_issue_arbiter: RTL and testbench
=======================================

# decode_issue_arbiter

Shares the single 32-bit decode input port between `NUM_REQ` instruction-bundle sources (fetch lanes or TB drivers). It grants one bundle at a time using round-robin arbitration, latches the bundle, and issues its 32-bit instructions one per handshake to decode. Each instruction is tagged with its source ID and a last-of-bundle flag. It sits between the fetch/driver stage and the decoder's `inst_valid`/`inst_ready` interface.

## Interface
- `WIDTH`, 64, bundle width in bits; multiple of 32, ≥32; `SLOTS = WIDTH/32`
- `NUM_REQ`, 2, number of requesters, ≥1; `SRC_W = max(1,$clog2(NUM_REQ))`, `CNT_W = $clog2(SLOTS+1)`
- `clk` in 1: clock
- `reset` in 1: reset, synchronous, active-high
- `req_valid` in NUM_REQ: per-requester bundle valid
- `req_ready` out NUM_REQ: one-hot grant; bundle accepted when valid&ready
- `req_bundle` in NUM_REQ*WIDTH: requester r occupies bits [r*WIDTH +: WIDTH]
- `req_count` in NUM_REQ*CNT_W: number of valid instructions in bundle, slot 0 first
- `flush` in 1: abort current bundle
- `inst_out` out 32: current instruction
- `inst_src` out SRC_W: granted requester index
- `inst_last` out 1: current instruction is final one of bundle
- `inst_valid` out 1: instruction valid
- `inst_ready` in 1: decoder accepts

## Operation
- FSM states: IDLE, ISSUE.
- IDLE:
  - If `flush`=0 and any `req_valid`, the winner is the first set bit at or after `rr_ptr`, wrapping.
  - `req_ready[winner]`=1 combinationally in the same cycle.
  - Latch bundle, count, and source; `idx`←0.
  - Next state is ISSUE, or IDLE if the latched count is 0.
- Count rules: count 0 means the bundle is accepted and dropped, with no instructions emitted. Count > SLOTS is clamped to SLOTS.
- ISSUE:
  - `inst_valid`=1 and `inst_out`=bundle[idx*32 +: 32].
  - `inst_last`=(idx==count-1).
  - On `inst_valid & inst_ready`: if last, go to IDLE; otherwise `idx`++.
- `rr_ptr` ← (winner+1) mod NUM_REQ when the bundle completes, is dropped (count 0), or is flushed.
- `flush` in ISSUE: next state IDLE, remaining slots discarded, `rr_ptr` advances.
  - A beat handshaken in the flush cycle counts as transferred.
  - `flush` in IDLE blocks any grant that cycle.
- `req_ready` is 0 in ISSUE. Only one requester is ever granted per cycle.
- `inst_out`, `inst_src`, and `inst_last` are stable while `inst_valid`=1 and `inst_ready`=0.
- `req_valid` is not required to be held by requesters. Only the grant-cycle values matter.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `idx`=0, `inst_valid`=0, `inst_out`=0, `inst_src`=0, `inst_last`=0, `req_ready`=0.
- Reset mid-ISSUE discards the bundle. `inst_valid`=0 on the following cycle.
- Latency: bundle accepted in cycle N → first instruction valid in cycle N+1.
- Throughput: one instruction per cycle while `inst_ready`=1. An n-instruction bundle occupies n ISSUE cycles plus 1 IDLE (arbitration) cycle.
- No combinational path from `inst_ready` to `inst_valid` or `inst_out`.
- Combinational paths: `req_valid` → `req_ready`, and `flush` → `req_ready`.

## Structure
- `decode_pkg` holds:
  - `INST_W`=32
  - the `issue_state_e` enum (IDLE, ISSUE)
  - a `src_id_t`-width helper function
- Sub-module `decode_rr_pick`: combinational round-robin picker. Inputs are the request vector and `rr_ptr`; outputs are the one-hot grant and the encoded index. It is reused by later fetch arbiters.
- Top-level registers: state, `rr_ptr`, `idx`, latched bundle (WIDTH), count (CNT_W), source (SRC_W).

## Test plan
- **Single bundle.** WIDTH=64, r0 presents bundle `0xBBBB_BBBB_AAAA_AAAA` with count 2, `inst_ready`=1.
  - Expect `req_ready[0]` in cycle 0.
  - Cycle 1: `0xAAAAAAAA` with last=0. Cycle 2: `0xBBBBBBBB` with last=1. `inst_src`=0.
- **Round-robin fairness.** r0 and r1 are continuously valid, each with count 2.
  - Grant order: r0, r1, r0, r1.
  - Each bundle spans 3 cycles (2 issue + 1 arbitration).
- **Backpressure.** Hold `inst_ready`=0 for 5 cycles mid-bundle.
  - `inst_out`, `inst_src`, and `inst_last` stay unchanged with `inst_valid`=1.
  - No new `req_ready` is asserted.
- **Partial, zero and oversized counts.**
  - count 1 → single beat with last=1.
  - count 0 → grant, no `inst_valid`, `rr_ptr` advances.
  - count 3 with SLOTS=2 → clamped to 2 beats.
- **Flush during issue.** Assert `flush` with `idx`=0 and `inst_ready`=1.
  - Slot 0 is transferred; `inst_valid`=0 next cycle; `rr_ptr` advances.
  - With `flush` asserted in IDLE, `req_ready`=0.
- **Reset mid-issue.** WIDTH=128, count 4, assert `reset` after 2 beats.
  - Next cycle: `inst_valid`=0 and `rr_ptr`=0.
  - Afterwards r0 is granted first again.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared constants, the issue-FSM state type and a width
//                helper for the decode issue arbiter and its neighbours.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

  localparam int INST_W = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } issue_state_e;

  // Width of a source-id field: a single requester still gets one bit so the
  // tag port never collapses to zero width.
  function automatic int src_id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_issue_arbiter_if
//  Description : Requester-side bundle handshake plus decoder-side
//                instruction handshake of the decode issue arbiter.
//  Ports       : req_valid/req_ready/req_bundle/req_count (per requester),
//                flush, inst_out/inst_src/inst_last/inst_valid/inst_ready.
//                master = fetch/decoder environment, slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_issue_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 64
);
  import decode_pkg::*;

  localparam int SLOTS = WIDTH / INST_W;
  localparam int SRC_W = src_id_w(NUM_REQ);
  localparam int CNT_W = $clog2(SLOTS + 1);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_bundle;
  logic [NUM_REQ*CNT_W-1:0] req_count;
  logic                     flush;
  logic [INST_W-1:0]        inst_out;
  logic [SRC_W-1:0]         inst_src;
  logic                     inst_last;
  logic                     inst_valid;
  logic                     inst_ready;

  modport master (
    output req_valid, req_bundle, req_count, flush, inst_ready,
    input  req_ready, inst_out, inst_src, inst_last, inst_valid
  );

  modport slave (
    input  req_valid, req_bundle, req_count, flush, inst_ready,
    output req_ready, inst_out, inst_src, inst_last, inst_valid
  );

endinterface
`default_nettype wire

// File: rtl/decode_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : decode_rr_pick
//  Description : Combinational round-robin picker. Selects the first set
//                request bit at or after rr_ptr, wrapping around.
//  Ports       : req (request vector), rr_ptr (priority start index),
//                grant (one-hot), grant_idx (encoded winner).
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int SRC_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [SRC_W-1:0]   grant_idx
);

  always_comb begin
    int   k;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = SRC_W'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : decode_issue_arbiter
//  Description : Round-robin shares the decode port between NUM_REQ bundle
//                sources. Latches one granted bundle and issues its 32-bit
//                instructions one per handshake, tagged with source id and
//                a last-of-bundle flag.
//  Ports       : clk, reset (sync, active-high), bus (slave modport of
//                decode_issue_arbiter_if).
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_issue_arbiter
  import decode_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  decode_issue_arbiter_if.slave  bus
);

  localparam int SLOTS = WIDTH / INST_W;
  localparam int SRC_W = src_id_w(NUM_REQ);
  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam logic [CNT_W-1:0] C_SLOTS    = CNT_W'(SLOTS);
  localparam logic [SRC_W-1:0] C_LAST_SRC = SRC_W'(NUM_REQ - 1);

  issue_state_e       r_state, w_state_n;
  logic [SRC_W-1:0]   r_rr_ptr, w_rr_ptr_n;
  logic [SRC_W-1:0]   r_src, w_src_n;
  logic [CNT_W-1:0]   r_idx, w_idx_n;
  logic [CNT_W-1:0]   r_count, w_count_n;
  logic [WIDTH-1:0]   r_bundle, w_bundle_n;

  logic [NUM_REQ-1:0] w_pick_grant;
  logic [SRC_W-1:0]   w_pick_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic [WIDTH-1:0]   w_sel_bundle;
  logic [CNT_W-1:0]   w_sel_count_raw;
  logic [CNT_W-1:0]   w_sel_count;
  logic [INST_W-1:0]  w_slot;
  logic               w_valid;
  logic               w_last;
  logic               w_fire;

  function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] p);
    return (p == C_LAST_SRC) ? '0 : p + SRC_W'(1);
  endfunction

  decode_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_rr_pick (
    .req       (bus.req_valid),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_pick_grant),
    .grant_idx (w_pick_idx)
  );

  // Winner's bundle and count; oversized counts are clamped to SLOTS.
  always_comb begin
    w_sel_bundle    = '0;
    w_sel_count_raw = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (int'(w_pick_idx) == r) begin
        w_sel_bundle    = bus.req_bundle[r*WIDTH +: WIDTH];
        w_sel_count_raw = bus.req_count[r*CNT_W +: CNT_W];
      end
    end
    w_sel_count = (w_sel_count_raw > C_SLOTS) ? C_SLOTS : w_sel_count_raw;
  end

  // Current slot comes only from registers, so inst_ready never reaches
  // inst_out or inst_valid combinationally.
  always_comb begin
    w_slot = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (int'(r_idx) == s) w_slot = r_bundle[s*INST_W +: INST_W];
    end
  end

  // Grants only in IDLE; flush (and reset) suppress arbitration that cycle.
  assign w_grant = (r_state == IDLE && !bus.flush && !reset) ? w_pick_grant : '0;
  assign w_valid = (r_state == ISSUE);
  assign w_last  = (r_idx == r_count - CNT_W'(1));
  assign w_fire  = w_valid && bus.inst_ready;

  assign bus.req_ready  = w_grant;
  assign bus.inst_valid = w_valid;
  assign bus.inst_out   = w_valid ? w_slot : '0;
  assign bus.inst_src   = r_src;
  assign bus.inst_last  = w_valid && w_last;

  always_comb begin
    w_state_n  = r_state;
    w_rr_ptr_n = r_rr_ptr;
    w_src_n    = r_src;
    w_idx_n    = r_idx;
    w_count_n  = r_count;
    w_bundle_n = r_bundle;
    case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_bundle_n = w_sel_bundle;
          w_count_n  = w_sel_count;
          w_src_n    = w_pick_idx;
          w_idx_n    = '0;
          // An empty bundle is consumed here without ever entering ISSUE.
          if (w_sel_count == '0) w_rr_ptr_n = next_ptr(w_pick_idx);
          else                   w_state_n  = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.flush || (w_fire && w_last)) begin
          w_state_n  = IDLE;
          w_rr_ptr_n = next_ptr(r_src);
        end else if (w_fire) begin
          w_idx_n = r_idx + CNT_W'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_src    <= '0;
      r_idx    <= '0;
      r_count  <= '0;
      r_bundle <= '0;
    end else begin
      r_state  <= w_state_n;
      r_rr_ptr <= w_rr_ptr_n;
      r_src    <= w_src_n;
      r_idx    <= w_idx_n;
      r_count  <= w_count_n;
      r_bundle <= w_bundle_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_decode_issue_arbiter
//  Description : Scoreboard bench for decode_issue_arbiter. dut_a uses
//                WIDTH=64, dut_b uses WIDTH=128 for the mid-bundle reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue_arbiter;

  localparam int NUM_REQ = 2;
  localparam int WA      = 64;
  localparam int WB      = 128;

  typedef struct packed {
    logic [31:0] data;
    logic [0:0]  src;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  decode_issue_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WA)) bus_a ();
  decode_issue_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WB)) bus_b ();

  decode_issue_arbiter #(.WIDTH(WA), .NUM_REQ(NUM_REQ)) dut_a (
    .clk(clk), .reset(rst_a), .bus(bus_a.slave));
  decode_issue_arbiter #(.WIDTH(WB), .NUM_REQ(NUM_REQ)) dut_b (
    .clk(clk), .reset(rst_b), .bus(bus_b.slave));

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  beat_t exp_a[$];
  beat_t exp_b[$];
  int    gnt_a[$];
  int    gnt_b[$];
  int    gtime_a[$];
  beat_t held[2];
  logic  stall[2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic beat_t mk(input logic [31:0] d, input logic s, input logic l);
    beat_t b;
    b.data = d; b.src = s; b.last = l;
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected grants/beats whenever the DUT presents them.
  task automatic monitor_step(input int sel, input logic rst, input logic [1:0] rdy,
                              input logic v, input logic ir, input logic [31:0] d,
                              input logic [0:0] s, input logic l);
    beat_t got, e;
    int    g;
    got = mk(d, s, l);
    if (rst) begin
      stall[sel] = 1'b0;
    end else begin
      if (rdy != 2'b00) begin
        if ((sel == 0) ? (gnt_a.size() == 0) : (gnt_b.size() == 0)) begin
          check("grant_unexpected", {62'b0, rdy}, 64'd0);
        end else begin
          g = (sel == 0) ? gnt_a.pop_front() : gnt_b.pop_front();
          check("grant_onehot", {62'b0, rdy}, 64'(1) << g);
          if (sel == 0) gtime_a.push_back(cyc);
        end
      end
      if (stall[sel]) begin
        check("hold_valid", {63'b0, v}, 64'd1);
        check("hold_out",   {32'b0, d}, {32'b0, held[sel].data});
        check("hold_src",   {63'b0, s}, {63'b0, held[sel].src});
        check("hold_last",  {63'b0, l}, {63'b0, held[sel].last});
      end
      if (v && ir) begin
        if ((sel == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0)) begin
          n_cmp++; n_bad++;
          $display("FAIL beat_unexpected: actual data=%0h src=%0d last=%0d required=no beat", d, s, l);
        end else begin
          e = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
          check("beat_data", {32'b0, got.data}, {32'b0, e.data});
          check("beat_src",  {63'b0, got.src},  {63'b0, e.src});
          check("beat_last", {63'b0, got.last}, {63'b0, e.last});
        end
      end
      stall[sel] = v && !ir;
      held[sel]  = got;
    end
  endtask

  always @(negedge clk)
    monitor_step(0, rst_a, bus_a.req_ready, bus_a.inst_valid, bus_a.inst_ready,
                 bus_a.inst_out, bus_a.inst_src, bus_a.inst_last);
  always @(negedge clk)
    monitor_step(1, rst_b, bus_b.req_ready, bus_b.inst_valid, bus_b.inst_ready,
                 bus_b.inst_out, bus_b.inst_src, bus_b.inst_last);

  // Present a bundle until granted, then withdraw; called just after a posedge.
  task automatic send(input int sel, input int r, input logic [127:0] b, input int cnt);
    bit done;
    done = 1'b0;
    if (sel == 0) begin
      bus_a.req_bundle[r*WA +: WA] = b[WA-1:0];
      bus_a.req_count[r*2 +: 2]    = 2'(cnt);
      bus_a.req_valid[r]           = 1'b1;
    end else begin
      bus_b.req_bundle[r*WB +: WB] = b;
      bus_b.req_count[r*3 +: 3]    = 3'(cnt);
      bus_b.req_valid[r]           = 1'b1;
    end
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if ((sel == 0) ? bus_a.req_ready[r] : bus_b.req_ready[r]) done = 1'b1;
      @(posedge clk); #1;
    end
    if (sel == 0) bus_a.req_valid[r] = 1'b0;
    else          bus_b.req_valid[r] = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: dut=%0d req=%0d actual=no grant required=grant", sel, r);
    end
  endtask

  task automatic wait_grant(input int sel, input int r);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if ((sel == 0) ? bus_a.req_ready[r] : bus_b.req_ready[r]) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_grant_timeout: dut=%0d req=%0d actual=no grant required=grant", sel, r);
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_a.size() + exp_b.size() + gnt_a.size() + gnt_b.size()) != 0 && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    check("drain_pending", 64'(exp_a.size() + exp_b.size() + gnt_a.size() + gnt_b.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stall[0] = 1'b0; stall[1] = 1'b0;
    held[0]  = '0;   held[1]  = '0;
    bus_a.req_valid = '0; bus_a.req_bundle = '0; bus_a.req_count = '0;
    bus_a.flush = 1'b0;   bus_a.inst_ready = 1'b1;
    bus_b.req_valid = '0; bus_b.req_bundle = '0; bus_b.req_count = '0;
    bus_b.flush = 1'b0;   bus_b.inst_ready = 1'b1;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_inst_valid", {63'b0, bus_a.inst_valid}, 64'd0);
    check("rst_inst_out",   {32'b0, bus_a.inst_out},   64'd0);
    check("rst_inst_src",   {63'b0, bus_a.inst_src},   64'd0);
    check("rst_inst_last",  {63'b0, bus_a.inst_last},  64'd0);
    check("rst_req_ready",  {62'b0, bus_a.req_ready},  64'd0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;

    // Round-robin fairness: both continuously valid, 3 cycles per bundle.
    gtime_a.delete();
    gnt_a.push_back(0); gnt_a.push_back(1); gnt_a.push_back(0); gnt_a.push_back(1);
    exp_a.push_back(mk(32'h0000_0001, 1'b0, 1'b0)); exp_a.push_back(mk(32'h0000_0002, 1'b0, 1'b1));
    exp_a.push_back(mk(32'h0000_0011, 1'b1, 1'b0)); exp_a.push_back(mk(32'h0000_0012, 1'b1, 1'b1));
    exp_a.push_back(mk(32'h0000_0003, 1'b0, 1'b0)); exp_a.push_back(mk(32'h0000_0004, 1'b0, 1'b1));
    exp_a.push_back(mk(32'h0000_0013, 1'b1, 1'b0)); exp_a.push_back(mk(32'h0000_0014, 1'b1, 1'b1));
    fork
      begin
        send(0, 0, 128'h0000_0002_0000_0001, 2);
        send(0, 0, 128'h0000_0004_0000_0003, 2);
      end
      begin
        send(0, 1, 128'h0000_0012_0000_0011, 2);
        send(0, 1, 128'h0000_0014_0000_0013, 2);
      end
    join
    drain();
    check("fair_grants", 64'(gtime_a.size()), 64'd4);
    if (gtime_a.size() == 4) begin
      for (int i = 1; i < 4; i++) check("fair_spacing", 64'(gtime_a[i] - gtime_a[i-1]), 64'd3);
    end

    // Single bundle from r0 with one-cycle latency.
    gnt_a.push_back(0);
    exp_a.push_back(mk(32'hAAAA_AAAA, 1'b0, 1'b0));
    exp_a.push_back(mk(32'hBBBB_BBBB, 1'b0, 1'b1));
    send(0, 0, 128'hBBBB_BBBB_AAAA_AAAA, 2);
    @(negedge clk);
    check("latency_valid", {63'b0, bus_a.inst_valid}, 64'd1);
    check("latency_data",  {32'b0, bus_a.inst_out},   64'hAAAA_AAAA);
    drain();

    // Backpressure: 5 stalled cycles on slot 1, r0 waits without a grant.
    gnt_a.push_back(1); gnt_a.push_back(0);
    exp_a.push_back(mk(32'h1111_1111, 1'b1, 1'b0));
    exp_a.push_back(mk(32'h2222_2222, 1'b1, 1'b1));
    exp_a.push_back(mk(32'h3333_3333, 1'b0, 1'b1));
    fork
      send(0, 1, 128'h2222_2222_1111_1111, 2);
      send(0, 0, 128'h0000_0000_3333_3333, 1);
      begin
        wait_grant(0, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_a.inst_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("bp_no_grant", {62'b0, bus_a.req_ready}, 64'd0);
          check("bp_valid",    {63'b0, bus_a.inst_valid}, 64'd1);
        end
        @(posedge clk); #1;
        bus_a.inst_ready = 1'b1;
      end
    join
    drain();

    // Count 1, count 0 (dropped, pointer advances), count 3 clamped to 2.
    gnt_a.push_back(1);
    exp_a.push_back(mk(32'h5555_5555, 1'b1, 1'b1));
    send(0, 1, 128'h0000_0000_5555_5555, 1);
    drain();
    gnt_a.push_back(0);
    send(0, 0, 128'h9898_9898_9797_9797, 0);
    @(negedge clk);
    check("cnt0_no_valid", {63'b0, bus_a.inst_valid}, 64'd0);
    drain();
    gnt_a.push_back(1); gnt_a.push_back(0);
    exp_a.push_back(mk(32'h6666_6666, 1'b1, 1'b0));
    exp_a.push_back(mk(32'h7777_7777, 1'b1, 1'b1));
    exp_a.push_back(mk(32'h8888_8888, 1'b0, 1'b1));
    fork
      send(0, 0, 128'h9999_9999_8888_8888, 1);
      send(0, 1, 128'h7777_7777_6666_6666, 3);
    join
    drain();

    // Flush at idx 0 with a handshake, then flush held in IDLE.
    gnt_a.push_back(1); gnt_a.push_back(0); gnt_a.push_back(1);
    exp_a.push_back(mk(32'hCCCC_CCCC, 1'b1, 1'b0));
    exp_a.push_back(mk(32'hE0E0_E0E0, 1'b0, 1'b1));
    exp_a.push_back(mk(32'h0BAD_F00D, 1'b1, 1'b1));
    fork
      send(0, 1, 128'hDDDD_DDDD_CCCC_CCCC, 2);
      begin
        wait_grant(0, 1);
        @(posedge clk); #1;
        bus_a.flush = 1'b1;
        @(posedge clk); #1;
        fork
          send(0, 0, 128'hF0F0_F0F0_E0E0_E0E0, 1);
          send(0, 1, 128'h1234_5678_0BAD_F00D, 1);
        join_none
        @(negedge clk);
        check("flush_valid_next", {63'b0, bus_a.inst_valid}, 64'd0);
        check("flush_idle_block", {62'b0, bus_a.req_ready}, 64'd0);
        @(posedge clk); #1;
        bus_a.flush = 1'b0;
        wait fork;
      end
    join
    drain();

    // WIDTH=128: move rr_ptr to 1, reset mid-bundle, r0 must win again.
    gnt_b.push_back(0);
    exp_b.push_back(mk(32'h0000_B001, 1'b0, 1'b1));
    send(1, 0, 128'h0000_B001, 1);
    drain();
    gnt_b.push_back(0);
    exp_b.push_back(mk(32'h1010_1010, 1'b0, 1'b0));
    exp_b.push_back(mk(32'h2020_2020, 1'b0, 1'b0));
    fork
      send(1, 0, 128'h4040_4040_3030_3030_2020_2020_1010_1010, 4);
      begin
        wait_grant(1, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", {63'b0, bus_b.inst_valid}, 64'd0);
      end
    join
    @(posedge clk); #1;
    gnt_b.push_back(0); gnt_b.push_back(1);
    exp_b.push_back(mk(32'h0000_B00A, 1'b0, 1'b1));
    exp_b.push_back(mk(32'h0000_B00B, 1'b1, 1'b1));
    fork
      send(1, 0, 128'h0000_B00A, 1);
      send(1, 1, 128'h0000_B00B, 1);
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
